// File: rtl/reservation_station_if.sv
// Dispatch, CDB and issue signals of one reservation station, grouped so that the
// dispatch side (master) and the station (slave) share a single port.
interface reservation_station_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [82:0]       in_inst;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       cdb_value;
  logic              out_valid;
  logic              out_ready;
  logic [82:0]       out_inst;
  logic [CW-1:0]     count;

  modport master (
    output flush, in_valid, in_inst, cdb_valid, cdb_tag, cdb_value, out_ready,
    input  in_ready, out_valid, out_inst, count
  );

  modport slave (
    input  flush, in_valid, in_inst, cdb_valid, cdb_tag, cdb_value, out_ready,
    output in_ready, out_valid, out_inst, count
  );
endinterface

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: holds dispatched instructions, captures
// missing operands from the CDB and issues the oldest fully-ready entry.
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  reservation_station_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] rs2_vt;
    logic        s2_valid;
    logic [31:0] rs1_vt;
    logic        s1_valid;
    logic [4:0]  rd;
    logic [11:0] ctrl;
  } rs_inst_t;

  rs_inst_t [DEPTH-1:0] ent_q, ent_d, woke;
  rs_inst_t             sel_inst, in_woke;
  logic [CW-1:0]        count_q, count_d, sel, wr_idx;
  logic                 found, issue, push;

  // Only sources still waiting are compared; a resolved value may alias a tag.
  function automatic rs_inst_t wake(input rs_inst_t e, input logic hit_v,
                                    input logic [TAG_W-1:0] tag, input logic [31:0] val);
    rs_inst_t r;
    r = e;
    if (hit_v && !e.s1_valid && e.rs1_vt[TAG_W-1:0] == tag) begin
      r.rs1_vt   = val;
      r.s1_valid = 1'b1;
    end
    if (hit_v && !e.s2_valid && e.rs2_vt[TAG_W-1:0] == tag) begin
      r.rs2_vt   = val;
      r.s2_valid = 1'b1;
    end
    return r;
  endfunction

  // Oldest-first select over registered state only.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_inst = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && CW'(i) < count_q && ent_q[i].s1_valid && ent_q[i].s2_valid) begin
        found    = 1'b1;
        sel      = CW'(i);
        sel_inst = ent_q[i];
      end
    end
  end

  assign bus.out_valid = found && !bus.flush;
  assign bus.out_inst  = bus.out_valid ? sel_inst : '0;
  assign bus.in_ready  = (count_q < CW'(DEPTH)) && !bus.flush;
  assign bus.count     = count_q;
  assign issue         = bus.out_valid && bus.out_ready;
  assign push          = bus.in_valid && bus.in_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      woke[i] = wake(ent_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    in_woke = wake(rs_inst_t'(bus.in_inst), bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

    ent_d = woke;
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (CW'(i) >= sel) ent_d[i] = woke[i + 1];
      ent_d[DEPTH-1] = '0;
    end

    // The new entry lands right above the post-collapse occupancy.
    wr_idx  = count_q - CW'(issue);
    count_d = count_q + CW'(push) - CW'(issue);
    if (push) begin
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == wr_idx) ent_d[i] = in_woke;
    end

    if (bus.flush) begin
      ent_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end
endmodule
